// File: rtl/rle_pkg.sv
// Shared types and helpers for the run-length encoder.
package rle_pkg;

  localparam int unsigned SYM_W      = 8;
  localparam int unsigned PAIR_W     = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_WAIT, ST_LOAD, ST_SCAN, ST_WR, ST_FLUSH, ST_DONE
  } rle_state_e;

  typedef struct packed {
    logic [SYM_W-1:0] cnt;
    logic [SYM_W-1:0] sym;
  } rle_pair_t;

  function automatic rle_pair_t pack_pair(input logic [SYM_W-1:0] cnt,
                                          input logic [SYM_W-1:0] sym);
    rle_pair_t p;
    p.cnt = cnt;
    p.sym = sym;
    return p;
  endfunction

endpackage

// File: rtl/rle_encoder_param_if.sv
// Single-port dpsram port A as seen by the encoder (master) and the memory (slave).
interface rle_encoder_param_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              port_A_clk;
  logic [ADDR_W-1:0] port_A_addr;
  logic [31:0]       port_A_data_in;
  logic [31:0]       port_A_data_out;
  logic              port_A_we;

  modport master (
    output port_A_clk, port_A_addr, port_A_data_in, port_A_we,
    input  port_A_data_out
  );

  modport slave (
    input  port_A_clk, port_A_addr, port_A_data_in, port_A_we,
    output port_A_data_out
  );
endinterface

// File: rtl/rle_pair_packer.sv
// Packs {count,byte} pairs two per word (low half first) and issues the one-cycle write.
module rle_pair_packer
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              clear,
  input  logic              push,
  input  logic              flush,
  input  rle_pair_t         pair,
  output logic              lo_vld,
  output logic              we,
  output logic [WORD_W-1:0] data
);

  rle_pair_t lo;

  // A flush always carries the frame's final pair; the high half is zero-padded if empty.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lo     <= '0;
      lo_vld <= 1'b0;
      we     <= 1'b0;
      data   <= '0;
    end else begin
      we <= 1'b0;
      if (clear) begin
        lo_vld <= 1'b0;
      end else if (flush) begin
        data   <= lo_vld ? {pair, lo} : {PAIR_W'(0), pair};
        we     <= 1'b1;
        lo_vld <= 1'b0;
      end else if (push) begin
        if (lo_vld) begin
          data   <= {pair, lo};
          we     <= 1'b1;
          lo_vld <= 1'b0;
        end else begin
          lo     <= pair;
          lo_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rle_encoder_param.sv
// Parametrised run-length encoder over a shared single-port dpsram.
// Optional RLE_STATS_EN adds pair_count / max_run frame statistics.
module rle_encoder_param
  import rle_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SIZE_W  = 32,
  parameter int unsigned MAX_RUN = 255,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [SIZE_W-1:0] message_size,
  input  logic [31:0]       rle_addr,
  output logic [SIZE_W-1:0] rle_size,
  output logic              done,
`ifdef RLE_STATS_EN
  output logic [SIZE_W-1:0] pair_count,
  output logic [7:0]        max_run,
`endif
  rle_encoder_param_if.master mem
);

  localparam int unsigned LAT_W = 4;

  rle_state_e        state, ret_state, scan_next_c;
  logic [ADDR_W-1:0] rd_addr, wr_addr, addr_q;
  logic [SIZE_W-1:0] remaining;
  logic [WORD_W-1:0] word;
  logic [1:0]        idx;
  logic [SYM_W-1:0]  cur, cnt, byte_c;
  logic [LAT_W-1:0]  wait_cnt;
  logic              first;
  logic              emit_c, flush_c, clear_c, lo_vld, wr_we;
  logic [WORD_W-1:0] wr_data;
  rle_pair_t         pair_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{message_addr, rle_addr};

  assign mem.port_A_clk     = clk;
  assign mem.port_A_addr    = addr_q;
  assign mem.port_A_we      = wr_we;
  assign mem.port_A_data_in = wr_data;

  // Byte selection, pair emission and the state SCAN falls into after this byte.
  always_comb begin
    byte_c      = word[{idx, 3'b000} +: SYM_W];
    emit_c      = (state == ST_SCAN) && !first &&
                  ((byte_c != cur) || (cnt >= SYM_W'(MAX_RUN)));
    flush_c     = (state == ST_FLUSH);
    clear_c     = start && ((state == ST_IDLE) || (state == ST_DONE));
    pair_c      = pack_pair(cnt, cur);
    scan_next_c = ST_SCAN;
    if (remaining == SIZE_W'(1))
      scan_next_c = ST_FLUSH;
    else if (idx == 2'd3)
      scan_next_c = ST_RD;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      rd_addr   <= '0;
      wr_addr   <= '0;
      addr_q    <= '0;
      remaining <= '0;
      word      <= '0;
      idx       <= '0;
      cur       <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
      first     <= 1'b0;
      rle_size  <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rd_addr   <= message_addr[ADDR_W-1:0];
            wr_addr   <= rle_addr[ADDR_W-1:0];
            remaining <= message_size;
            rle_size  <= '0;
            first     <= 1'b1;
            if (message_size == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state  <= ST_RD;
              done   <= 1'b0;
              addr_q <= message_addr[ADDR_W-1:0];
            end
          end
        end
        ST_RD: begin
          rd_addr  <= rd_addr + ADDR_W'(WORD_BYTES);
          wait_cnt <= '0;
          state    <= (RD_LAT > 1) ? ST_WAIT : ST_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt == LAT_W'(RD_LAT - 2))
            state <= ST_LOAD;
          else
            wait_cnt <= wait_cnt + LAT_W'(1);
        end
        ST_LOAD: begin
          word  <= mem.port_A_data_out;
          idx   <= '0;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          remaining <= remaining - SIZE_W'(1);
          idx       <= idx + 2'd1;
          if (first || emit_c) begin
            cur   <= byte_c;
            cnt   <= SYM_W'(1);
            first <= 1'b0;
          end else begin
            cnt <= cnt + SYM_W'(1);
          end
          // A second pending pair completes a word: write it before resuming.
          if (emit_c && lo_vld) begin
            state     <= ST_WR;
            ret_state <= scan_next_c;
            addr_q    <= wr_addr;
          end else begin
            state <= scan_next_c;
            if (scan_next_c == ST_RD)
              addr_q <= rd_addr;
          end
        end
        ST_WR: begin
          wr_addr  <= wr_addr + ADDR_W'(WORD_BYTES);
          rle_size <= rle_size + SIZE_W'(WORD_BYTES);
          state    <= ret_state;
          if (ret_state == ST_RD)
            addr_q <= rd_addr;
          if (ret_state == ST_DONE)
            done <= 1'b1;
        end
        ST_FLUSH: begin
          state     <= ST_WR;
          ret_state <= ST_DONE;
          addr_q    <= wr_addr;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RLE_STATS_EN
  // Frame statistics over emitted pairs, pad half excluded.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pair_count <= '0;
      max_run    <= '0;
    end else if (clear_c) begin
      pair_count <= '0;
      max_run    <= '0;
    end else if (emit_c || flush_c) begin
      pair_count <= pair_count + SIZE_W'(1);
      if (cnt > max_run)
        max_run <= cnt;
    end
  end
`endif

  rle_pair_packer u_packer (
    .clk    (clk),
    .nreset (nreset),
    .clear  (clear_c),
    .push   (emit_c),
    .flush  (flush_c),
    .pair   (pair_c),
    .lo_vld (lo_vld),
    .we     (wr_we),
    .data   (wr_data)
  );

endmodule

// File: tb/tb_rle_encoder_param.sv
// Directed bench for rle_encoder_param: one RD_LAT=1 and one RD_LAT=2 instance on a shared memory.
module tb_rle_encoder_param;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start_a, start_b;
  logic [31:0] message_addr, message_size, rle_addr;
  logic [31:0] rle_size_a, rle_size_b;
  logic        done_a, done_b;
`ifdef RLE_STATS_EN
  logic [31:0] pair_count_a, pair_count_b;
  logic [7:0]  max_run_a, max_run_b;
`endif

  int errors = 0;
  int checks = 0;
  int wr_a = 0;
  int wr_b = 0;

  always #5 clk = ~clk;

  rle_encoder_param_if #(.ADDR_W(16)) if_a ();
  rle_encoder_param_if #(.ADDR_W(16)) if_b ();

  rle_encoder_param #(.ADDR_W(16), .SIZE_W(32), .MAX_RUN(255), .RD_LAT(1)) dut_a (
    .clk(clk), .nreset(nreset), .start(start_a),
    .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
    .rle_size(rle_size_a), .done(done_a),
`ifdef RLE_STATS_EN
    .pair_count(pair_count_a), .max_run(max_run_a),
`endif
    .mem(if_a)
  );

  rle_encoder_param #(.ADDR_W(16), .SIZE_W(32), .MAX_RUN(255), .RD_LAT(2)) dut_b (
    .clk(clk), .nreset(nreset), .start(start_b),
    .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
    .rle_size(rle_size_b), .done(done_b),
`ifdef RLE_STATS_EN
    .pair_count(pair_count_b), .max_run(max_run_b),
`endif
    .mem(if_b)
  );

  // Shared dpsram model with per-port read latency 1 (A) and 2 (B).
  logic [31:0] mem [0:16383];
  logic [31:0] a_d1, b_d1, b_d2;

  always @(posedge clk) begin
    if (if_a.port_A_we) begin
      mem[if_a.port_A_addr[15:2]] <= if_a.port_A_data_in;
      wr_a <= wr_a + 1;
    end
    if (if_b.port_A_we) begin
      mem[if_b.port_A_addr[15:2]] <= if_b.port_A_data_in;
      wr_b <= wr_b + 1;
    end
    a_d1 <= mem[if_a.port_A_addr[15:2]];
    b_d1 <= mem[if_b.port_A_addr[15:2]];
    b_d2 <= b_d1;
  end

  assign if_a.port_A_data_out = a_d1;
  assign if_b.port_A_data_out = b_d2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [15:0] a);
    return mem[a[15:2]];
  endfunction

  // Starts a frame, scrambles the inputs afterwards, pokes start mid-frame, waits for done.
  task automatic run_frame(input bit use_b, input logic [31:0] maddr, input logic [31:0] msize,
                           input logic [31:0] raddr, output int edges);
    message_addr = maddr;
    message_size = msize;
    rle_addr     = raddr;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a      = 1'b0;
    start_b      = 1'b0;
    message_addr = 32'h0000_FFF0;
    message_size = 32'd3;
    rle_addr     = 32'h0000_FFE0;
    edges        = 1;
    while (!(use_b ? done_b : done_a) && edges < 2000) begin
      if (use_b) start_b = (edges == 3 && msize > 4);
      else       start_a = (edges == 3 && msize > 4);
      @(negedge clk);
      edges++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check("done_reached", 64'(use_b ? done_b : done_a), 64'd1);
  endtask

  int e, w0;

  initial begin
    nreset       = 1'b0;
    start_a      = 1'b0;
    start_b      = 1'b0;
    message_addr = '0;
    message_size = '0;
    rle_addr     = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hDEAD_BEEF;
    mem[16'h0100 >> 2] = 32'h4141_4141;
    mem[16'h0104 >> 2] = 32'h4141_4141;
    mem[16'h0200 >> 2] = 32'h0302_0101;
    mem[16'h0204 >> 2] = 32'hEEEE_EE03;
    mem[16'h0300 >> 2] = 32'h5555_2211;
    mem[16'h0304 >> 2] = 32'h7766_5555;
    for (int i = 0; i < 75; i++) mem[(16'h1000 >> 2) + i] = 32'hAAAA_AAAA;

    repeat (2) @(negedge clk);
    check("rst_done",    64'(done_a), 64'd0);
    check("rst_rle_size", 64'(rle_size_a), 64'd0);
    check("rst_we",      64'(if_a.port_A_we), 64'd0);
    check("rst_addr",    64'(if_a.port_A_addr), 64'd0);
    check("rst_data_in", 64'(if_a.port_A_data_in), 64'd0);
    check("port_clk",    64'(if_a.port_A_clk), 64'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Eight identical bytes: one pair, padded.
    w0 = wr_a;
    run_frame(1'b0, 32'h0100, 32'd8, 32'h0800, e);
    check("t1_latency",  64'(e), 64'd15);
    check("t1_word",     64'(rd_mem(16'h0800)), 64'h0000_0841);
    check("t1_untouched", 64'(rd_mem(16'h0804)), 64'hDEAD_BEEF);
    check("t1_rle_size", 64'(rle_size_a), 64'd4);
    check("t1_writes",   64'(wr_a - w0), 64'd1);

    // Mixed runs, restart from DONE.
    w0 = wr_a;
    run_frame(1'b0, 32'h0200, 32'd5, 32'h0900, e);
    check("t2_latency",  64'(e), 64'd13);
    check("t2_word0",    64'(rd_mem(16'h0900)), 64'h0102_0201);
    check("t2_word1",    64'(rd_mem(16'h0904)), 64'h0000_0203);
    check("t2_rle_size", 64'(rle_size_a), 64'd8);
    check("t2_writes",   64'(wr_a - w0), 64'd2);
`ifdef RLE_STATS_EN
    check("t2_pair_count", 64'(pair_count_a), 64'd3);
    check("t2_max_run",    64'(max_run_a), 64'd2);
`endif

    // 300-byte run split at MAX_RUN.
    run_frame(1'b0, 32'h1000, 32'd300, 32'h0A00, e);
    check("t3_word",     64'(rd_mem(16'h0A00)), 64'h2DAA_FFAA);
    check("t3_untouched", 64'(rd_mem(16'h0A04)), 64'hDEAD_BEEF);
    check("t3_rle_size", 64'(rle_size_a), 64'd4);
`ifdef RLE_STATS_EN
    check("t3_pair_count", 64'(pair_count_a), 64'd2);
    check("t3_max_run",    64'(max_run_a), 64'd255);
`endif

    // Abort mid-frame with nreset, then a clean frame.
    w0 = wr_a;
    message_addr = 32'h1000;
    message_size = 32'd300;
    rle_addr     = 32'h0D00;
    start_a      = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("abort_done", 64'(done_a), 64'd0);
    check("abort_we",   64'(if_a.port_A_we), 64'd0);
    check("abort_addr", 64'(if_a.port_A_addr), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("abort_writes",  64'(wr_a - w0), 64'd0);
    check("abort_nowrite", 64'(rd_mem(16'h0D00)), 64'hDEAD_BEEF);
    run_frame(1'b0, 32'h0200, 32'd5, 32'h0E00, e);
    check("post_latency",  64'(e), 64'd13);
    check("post_word0",    64'(rd_mem(16'h0E00)), 64'h0102_0201);
    check("post_word1",    64'(rd_mem(16'h0E04)), 64'h0000_0203);
    check("post_rle_size", 64'(rle_size_a), 64'd8);

    // Empty frame.
    w0 = wr_a;
    run_frame(1'b0, 32'h1400, 32'd0, 32'h0B00, e);
    check("t0_latency",  64'(e), 64'd1);
    check("t0_rle_size", 64'(rle_size_a), 64'd0);
    check("t0_writes",   64'(wr_a - w0), 64'd0);

    // RD_LAT=2, run crossing a word boundary.
    w0 = wr_b;
    run_frame(1'b1, 32'h0300, 32'd8, 32'h0C00, e);
    check("b_word0",    64'(rd_mem(16'h0C00)), 64'h0122_0111);
    check("b_word1",    64'(rd_mem(16'h0C04)), 64'h0166_0455);
    check("b_word2",    64'(rd_mem(16'h0C08)), 64'h0000_0177);
    check("b_rle_size", 64'(rle_size_b), 64'd12);
    check("b_writes",   64'(wr_b - w0), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
